// File: rtl/l2_wb_dispatch_if.sv
// L2->LLC writeback request channel: valid/ready handshake plus the line payload.
// The dispatcher drives the master side; payload holds stable while valid is high and ready is low.
interface l2_wb_dispatch_if #(
    parameter int ADDR_BITS = 32,
    parameter int LINE_BITS = 128,
    parameter int WORDS     = 4
);
    logic                 llc_req_valid;
    logic                 llc_req_ready;
    logic [2:0]           llc_req_msg;
    logic [ADDR_BITS-1:0] llc_req_addr;
    logic [LINE_BITS-1:0] llc_req_line;
    logic [WORDS-1:0]     llc_req_mask;

    modport master (
        output llc_req_valid, llc_req_msg, llc_req_addr, llc_req_line, llc_req_mask,
        input  llc_req_ready
    );

    modport slave (
        input  llc_req_valid, llc_req_msg, llc_req_addr, llc_req_line, llc_req_mask,
        output llc_req_ready
    );
endinterface

// File: rtl/l2_wb_dispatch.sv
// Purpose: drains L2 write-buffer entries to the LLC (single evict or full drain), round-robin victim order.
// Latency: request -> llc_req_valid 3 cycles, entry clear on the cycle after the handshake.
// Backpressure: holds the request stable in SEND until llc_req_ready; optional L2_WB_DISPATCH_SKIP_EMPTY_EN.
module l2_wb_dispatch #(
    parameter int         N_WB      = 4,
    parameter int         WB_BITS   = 2,
    parameter int         TAG_BITS  = 20,
    parameter int         SET_BITS  = 8,
    parameter int         OFF_BITS  = 4,
    parameter int         WORDS     = 4,
    parameter int         LINE_BITS = 128,
    parameter logic [2:0] WB_MSG    = 3'd4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_evict_req,
    input  logic                 i_drain_req,
    input  logic [N_WB-1:0]      i_wb_valid_vec,
    output logic [WB_BITS-1:0]   o_rd_idx,
    input  logic [TAG_BITS-1:0]  i_rd_tag,
    input  logic [SET_BITS-1:0]  i_rd_set,
    input  logic [LINE_BITS-1:0] i_rd_line,
    input  logic [WORDS-1:0]     i_rd_word_mask,
    l2_wb_dispatch_if.master     llc,
    output logic                 o_clear_wb_entry,
    output logic [WB_BITS-1:0]   o_wb_evict_buf,
    output logic                 o_busy,
    output logic                 o_drain_active,
    output logic                 o_evict_done,
    output logic                 o_drain_done
);

    localparam int ADDR_BITS = TAG_BITS + SET_BITS + OFF_BITS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_LOAD   = 3'd2,
        S_SEND   = 3'd3,
        S_CLEAR  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_drain;
    logic                  r_evict_too;
    logic [WB_BITS-1:0]    r_rr_ptr;
    logic [WB_BITS-1:0]    r_evict_buf;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [LINE_BITS-1:0]  r_line;
    logic [WORDS-1:0]      r_mask;
    logic                  w_found;
    logic [WB_BITS-1:0]    w_sel;

    // Scan downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        int c;
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        for (int k = N_WB - 1; k >= 0; k--) begin
            c = (int'(r_rr_ptr) + k) % N_WB;
            if (i_wb_valid_vec[c]) begin
                w_found = 1'b1;
                w_sel   = WB_BITS'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_drain_req || i_evict_req) w_next = S_SELECT;
            S_SELECT: w_next = w_found ? S_LOAD : S_IDLE;
`ifdef L2_WB_DISPATCH_SKIP_EMPTY_EN
            S_LOAD:   w_next = (i_rd_word_mask == '0) ? S_CLEAR : S_SEND;
`else
            S_LOAD:   w_next = S_SEND;
`endif
            S_SEND:   if (llc.llc_req_ready) w_next = S_CLEAR;
            S_CLEAR:  w_next = r_drain ? S_SELECT : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // An evict that arrived alongside a drain completes when the drain does.
    always_comb begin
        o_busy           = (r_state != S_IDLE);
        o_drain_active   = (r_state != S_IDLE) && r_drain;
        o_clear_wb_entry = (r_state == S_CLEAR);
        llc.llc_req_valid = (r_state == S_SEND);
        o_drain_done     = (r_state == S_SELECT) && !w_found && r_drain;
        o_evict_done     = ((r_state == S_SELECT) && !w_found && (!r_drain || r_evict_too)) ||
                           ((r_state == S_CLEAR) && !r_drain);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drain     <= 1'b0;
            r_evict_too <= 1'b0;
            r_rr_ptr    <= '0;
            r_evict_buf <= '0;
            r_addr      <= '0;
            r_line      <= '0;
            r_mask      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_drain_req || i_evict_req) begin
                        r_drain     <= i_drain_req;
                        r_evict_too <= i_drain_req && i_evict_req;
                    end
                end
                S_SELECT: if (w_found) r_evict_buf <= w_sel;
                S_LOAD: begin
                    r_addr <= {i_rd_tag, i_rd_set, {OFF_BITS{1'b0}}};
                    r_line <= i_rd_line;
                    r_mask <= i_rd_word_mask;
                end
                S_CLEAR:  r_rr_ptr <= WB_BITS'((int'(r_evict_buf) + 1) % N_WB);
                default: ;
            endcase
        end
    end

    assign o_rd_idx         = r_evict_buf;
    assign o_wb_evict_buf   = r_evict_buf;
    assign llc.llc_req_msg  = WB_MSG;
    assign llc.llc_req_addr = r_addr;
    assign llc.llc_req_line = r_line;
    assign llc.llc_req_mask = r_mask;

endmodule
